// File: rtl/reg_fifo.sv
// Register-based synchronous FIFO with first-word-fall-through output.
// Handshake flags depend only on registered occupancy, so neither side sees a combinational path.
module reg_fifo #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [BIT_WIDTH-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [BIT_WIDTH-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push, pop;

  assign in_ready  = (count_q != CntFull);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; a stray write during flush or reset is invisible once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo: stimulus queues expected words, a negedge monitor
// pops and compares every word the DUT hands over.
module tb_reg_fifo;

  localparam int unsigned BW = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  always #5 clk = ~clk;

  reg_fifo #(.BIT_WIDTH(BW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  // Drive one cycle of inputs; acc says whether this push is expected to be accepted.
  task automatic drive(input logic rs, input logic fl, input logic v, input logic [BW-1:0] d,
                       input logic r, input logic acc);
    if (!rs || fl) exp_q.delete();
    rst_n     = rs;
    flush     = fl;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name, input int exp_cnt);
    checks++;
    if (count !== CW'(exp_cnt) || in_ready !== (exp_cnt != DP) || out_valid !== (exp_cnt != 0)) begin
      errors++;
      $display("FAIL %s: count=%0d in_ready=%b out_valid=%b, required count=%0d in_ready=%b out_valid=%b",
               name, count, in_ready, out_valid, exp_cnt, (exp_cnt != DP), (exp_cnt != 0));
    end
  endtask

  task automatic check_head(input string name, input logic [BW-1:0] exp_d);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d) begin
      errors++;
      $display("FAIL %s: out_valid=%b out_data=%h, required out_valid=1 out_data=%h",
               name, out_valid, out_data, exp_d);
    end
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_data: got %h, required no output word", out_data);
        end else begin
          logic [BW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %h, required %h", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 0);

    // Fill to full; fifth push rejected.
    for (int i = 1; i <= 4; i++) drive(1, 0, 1, BW'(i), 0, 1);
    check_status("full", 4);
    check_head("full_head", 16'h0001);
    drive(1, 0, 1, 16'h0005, 0, 0);
    check_status("full_reject", 4);
    check_head("full_reject_head", 16'h0001);

    // Push while full alongside a pop: pop wins, push rejected.
    drive(1, 0, 1, 16'h0005, 1, 0);
    check_status("full_pop", 3);
    check_head("full_pop_head", 16'h0002);

    // Down to two, then simultaneous push/pop.
    drive(1, 0, 0, 16'h0000, 1, 0);
    check_status("count2", 2);
    drive(1, 0, 1, 16'hAAAA, 1, 1);
    check_status("push_pop", 2);
    check_head("push_pop_head", 16'h0004);
    drive(1, 0, 0, 16'h0000, 1, 0);
    drive(1, 0, 0, 16'h0000, 1, 0);
    check_status("drained", 0);
    drive(1, 0, 0, 16'h0000, 1, 0);
    check_status("pop_empty", 0);

    // Streaming with one-cycle latency, pointers wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, BW'(16'h0100 + i), 1, 1);
      check_status("stream", 1);
      check_head("stream_head", BW'(16'h0100 + i));
    end
    drive(1, 0, 0, 16'h0000, 1, 0);
    check_status("stream_end", 0);

    // Flush beats a concurrent push.
    drive(1, 0, 1, 16'h0011, 0, 1);
    drive(1, 0, 1, 16'h0022, 0, 1);
    drive(1, 0, 1, 16'h0033, 0, 1);
    check_status("pre_flush", 3);
    drive(1, 1, 1, 16'h0044, 1, 0);
    check_status("flush", 0);

    // Reset mid-operation discards stored words.
    drive(1, 0, 1, 16'h0055, 0, 1);
    drive(1, 0, 1, 16'h0066, 0, 1);
    check_status("pre_reset", 2);
    drive(0, 0, 0, 16'h0000, 1, 0);
    check_status("mid_reset", 0);
    drive(1, 0, 1, 16'hBEEF, 0, 1);
    check_status("post_reset_push", 1);
    check_head("post_reset_head", 16'hBEEF);
    drive(1, 0, 0, 16'h0000, 1, 0);
    check_status("final", 0);
    drive(1, 0, 0, 16'h0000, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL undelivered: %0d words left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 Parameter BIT_WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 4, number of storage entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 flush  input  1  synchronous clear of all stored entries.
REQ-006 in_data  input  BIT_WIDTH  write-side data word.
REQ-007 in_valid  input  1  write-side word present.
REQ-008 in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 out_data  output  BIT_WIDTH  head-of-queue word, meaningful only when out_valid=1.
REQ-010 out_valid  output  1  head word present.
REQ-011 out_ready  input  1  read-side consumer accepts the head word this cycle.
REQ-012 count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-013 The FIFO SHALL complete a push when in_valid=1 and in_ready=1 at a rising edge.
REQ-014 The FIFO SHALL complete a pop when out_valid=1 and out_ready=1 at a rising edge.
REQ-015 in_ready SHALL equal (count != DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0) and SHALL be a function of registered state only, with no combinational path from in_valid.
REQ-017 out_data SHALL present the oldest stored word first-word-fall-through, with no read latency after out_valid rises.
REQ-018 Latency: a word pushed at edge N SHALL be visible on out_data with out_valid=1 from the cycle after edge N.
REQ-019 Words SHALL be delivered in push order, with no loss or duplication.
REQ-020 Write and read pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-021 Push-only SHALL increment count by 1, pop-only SHALL decrement it by 1, and simultaneous push and pop SHALL leave count unchanged.
REQ-022 When full (count=DEPTH), in_ready=0, so a push in the same cycle as a pop SHALL be rejected; in_ready SHALL rise the cycle after the pop.
REQ-023 When empty, a push SHALL be accepted and no pop SHALL occur that cycle, even with out_ready=1.
REQ-024 in_valid=1 while in_ready=0 SHALL leave state unchanged; the producer holds the word.
REQ-025 out_ready=1 while out_valid=0 SHALL leave state unchanged.
REQ-026 flush=1 at an edge SHALL set both pointers and count to 0, overriding any push or pop that cycle.
REQ-027 Storage array contents SHALL NOT require reset; only pointers and count are reset.

Reset
REQ-028 rst_n=0 at a rising edge SHALL set both pointers to 0 and count to 0, giving out_valid=0 and in_ready=1 from the next cycle.
REQ-029 Reset SHALL take priority over flush, push and pop.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; no stale word SHALL appear on out_valid after reset releases.
REQ-031 The first push after reset release SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-032 Bench: reset, push 0x0001..0x0004 with out_ready=0 -> count=4, in_ready=0, out_data=0x0001; a 5th push (0x0005) is not accepted.
REQ-033 Bench: from full, out_ready=1 and in_valid=1 (0x0005) for one cycle -> 0x0001 popped, 0x0005 rejected, count=3, in_ready=1 next cycle.
REQ-034 Bench: from count=2, push 0xAAAA and pop in the same cycle -> count stays 2 and order is preserved.
REQ-035 Bench: stream 10 words 0x0100..0x0109 with out_ready=1 every cycle -> pointers wrap twice and the output sequence is identical with one-cycle latency.
REQ-036 Bench: with count=3, assert flush together with in_valid=1 -> count=0 and out_valid=0 next cycle, and the pushed word is dropped.
REQ-037 Bench: with count=2, assert rst_n=0 for one cycle -> count=0, out_valid=0, in_ready=1; a subsequent push of 0xBEEF is the first word out.
